// File: rtl/n1_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : n1_irq_ctrl
// Purpose  : Interrupt controller for the N1 core. Captures 16 request lines
//            in edge or level mode, masks them per line, selects the winner
//            by fixed priority above the current in-service level, issues it
//            to the flow controller over a req/ack handshake and tracks
//            nested in-service interrupts until end-of-interrupt.
// Ports    : clk_i, async_rst_i (async, active-low)
//            irq_req_i[15:0]         raw request lines
//            excpt2irq_en_i          global interrupt enable
//            cfg_mask_we_i/mode_we_i write strobes, data on cfg_dat_i
//            irq2fc_req_o/vec_o      request + vector to flow controller
//            fc2irq_ack_i/eoi_i      accept / end-of-interrupt
//            prb_*_o                 probe outputs of internal state
// Options  : N1_IRQ_SYNC_EN - two-flop synchroniser ahead of the sample
//            register for asynchronous request sources (+2 cycles latency).
// Revision : 1.0 - initial release
// ============================================================================
module n1_irq_ctrl #(
  parameter int IRQ_CNT = 16,
  parameter int VEC_W   = 4
) (
  input  logic               clk_i,
  input  logic               async_rst_i,
  input  logic [IRQ_CNT-1:0] irq_req_i,
  input  logic               excpt2irq_en_i,
  input  logic               cfg_mask_we_i,
  input  logic               cfg_mode_we_i,
  input  logic [IRQ_CNT-1:0] cfg_dat_i,
  output logic               irq2fc_req_o,
  output logic [VEC_W-1:0]   irq2fc_vec_o,
  input  logic               fc2irq_ack_i,
  input  logic               fc2irq_eoi_i,
  output logic [IRQ_CNT-1:0] prb_mask_o,
  output logic [IRQ_CNT-1:0] prb_mode_o,
  output logic [IRQ_CNT-1:0] prb_pend_o,
  output logic [IRQ_CNT-1:0] prb_isr_o,
  output logic               prb_state_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IRQ_CNT-1:0] r_smp, r_prev, r_mask, r_mode, r_pend, r_isr;
  logic [VEC_W-1:0]   r_vec;
  logic [IRQ_CNT-1:0] w_smp_src, w_rise, w_above, w_elig, w_isr_top;
  logic [IRQ_CNT-1:0] w_vec_oh, w_ack_clr, w_pend_nxt, w_isr_nxt;
  logic [VEC_W-1:0]   w_win;
  logic               w_load_vec, w_ack;

  // --------------------------------------------------------------------------
  // Input stage
  // --------------------------------------------------------------------------
`ifdef N1_IRQ_SYNC_EN
  logic [IRQ_CNT-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_req_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_smp_src = r_sync2;
`else
  assign w_smp_src = irq_req_i;
`endif

  assign w_rise = r_smp & ~r_prev;

  // --------------------------------------------------------------------------
  // Priority logic: higher index wins; only lines strictly above the highest
  // in-service line may preempt.
  // --------------------------------------------------------------------------
  always_comb begin
    w_above   = '1;
    w_isr_top = '0;
    w_win     = '0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      if (r_isr[i]) begin
        // Ascending scan: the last hit is the highest in-service line, and
        // clearing everything at or below each hit leaves exactly that cut.
        for (int j = 0; j < IRQ_CNT; j++) begin
          if (j <= i) w_above[j] = 1'b0;
        end
        w_isr_top    = '0;
        w_isr_top[i] = 1'b1;
      end
    end
    w_elig = r_pend & r_mask & w_above;
    for (int i = 0; i < IRQ_CNT; i++) begin
      if (w_elig[i]) w_win = VEC_W'(i);
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load_vec  = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (excpt2irq_en_i && (|w_elig)) begin
          w_load_vec  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fc2irq_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!excpt2irq_en_i || !w_elig[r_vec]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending / in-service next state
  // --------------------------------------------------------------------------
  assign w_vec_oh  = IRQ_CNT'(1) << r_vec;
  assign w_ack_clr = w_ack ? (w_vec_oh & r_mode) : '0;

  always_comb begin
    // Edge lines: sticky, cleared by ack, a new rise wins over the clear.
    // Level lines: follow the sampled input.
    w_pend_nxt = (r_mode & ((r_pend & ~w_ack_clr) | w_rise)) | (~r_mode & r_smp);
    if (cfg_mode_we_i) begin
      w_pend_nxt = ~cfg_dat_i & r_smp;
    end

    // EOI retires the pre-ack top level, then the ack adds its own bit.
    w_isr_nxt = r_isr;
    if (fc2irq_eoi_i) w_isr_nxt = w_isr_nxt & ~w_isr_top;
    if (w_ack)        w_isr_nxt = w_isr_nxt | w_vec_oh;
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      r_smp   <= '0;
      r_prev  <= '0;
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_isr   <= '0;
      r_vec   <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_smp   <= w_smp_src;
      r_prev  <= r_smp;
      r_pend  <= w_pend_nxt;
      r_isr   <= w_isr_nxt;
      r_state <= w_state_nxt;
      if (cfg_mask_we_i) r_mask <= cfg_dat_i;
      if (cfg_mode_we_i) r_mode <= cfg_dat_i;
      if (w_load_vec)    r_vec  <= w_win;
    end
  end

  assign irq2fc_req_o = (r_state == ST_REQ);
  assign irq2fc_vec_o = r_vec;
  assign prb_mask_o   = r_mask;
  assign prb_mode_o   = r_mode;
  assign prb_pend_o   = r_pend;
  assign prb_isr_o    = r_isr;
  assign prb_state_o  = r_state;

endmodule
`default_nettype wire

// File: doc/n1_irq_ctrl.md
# n1_irq_ctrl

Interrupt controller that sits between the 16 external `irq_req_i` lines and the exception aggregator/flow controller of the N1 core. It captures requests per line in edge or level mode and masks them per line. It picks the winner by fixed priority above the current in-service level, hands the vector to the flow controller over a req/ack handshake, and tracks nested in-service interrupts until end-of-interrupt.

## Interface
- `IRQ_CNT`, 16, number of interrupt lines (fixed at 16 in this release)
- `VEC_W`, 4, vector width; must equal log2(`IRQ_CNT`)
- `clk_i`  in  1  module clock; all state changes on rising edge
- `async_rst_i`  in  1  asynchronous reset, active-low
- `irq_req_i`  in  16  raw interrupt request lines, active high
- `excpt2irq_en_i`  in  1  global interrupt enable from the exception aggregator
- `cfg_mask_we_i`  in  1  write strobe for the mask register
- `cfg_mode_we_i`  in  1  write strobe for the mode register
- `cfg_dat_i`  in  16  write data for mask/mode; bit n = line n
- `irq2fc_req_o`  out  1  interrupt request to the flow controller
- `irq2fc_vec_o`  out  4  vector of the requested interrupt
- `fc2irq_ack_i`  in  1  flow controller accepts the vector
- `fc2irq_eoi_i`  in  1  end of interrupt; retires the highest in-service level
- `prb_mask_o`  out  16  mask register (1 = enabled)
- `prb_mode_o`  out  16  mode register (1 = edge, 0 = level)
- `prb_pend_o`  out  16  pending register
- `prb_isr_o`  out  16  in-service register
- `prb_state_o`  out  1  FSM state (0 = IDLE, 1 = REQ)

## Operation
- **Input stage:** `irq_req_i` is registered once into `smp`. `prev` holds the previous `smp`.
- **Edge line:** the pending bit is set when `smp & ~prev`. It clears when that vector is acked. If a set and an ack-clear hit the same bit in the same cycle, the set wins.
- **Level line:** the pending bit equals `smp`. Ack does not clear it.
- **Eligibility:** `elig = pend & mask & above`, where `above` contains the bits with index strictly greater than the highest set `isr` bit. When `isr` is 0, all bits are in `above`. Higher index means higher priority.
- **Winner:** the highest set bit of `elig`.
- **FSM IDLE:** if `excpt2irq_en_i` is high and `elig` is nonzero, latch the winner into `vec`, set `irq2fc_req_o`, and go to REQ.
- **FSM REQ:** `irq2fc_req_o` and `irq2fc_vec_o` stay stable.
  - If `fc2irq_ack_i` is high: set `isr[vec]`, clear `pend[vec]` for an edge line, drop `req`, and go to IDLE.
  - Otherwise, withdraw (drop `req`, go to IDLE) when `excpt2irq_en_i` is low or `elig[vec]` is 0, e.g. a level line fell or a mask bit was cleared.
  - A higher-priority arrival during REQ does not replace `vec`. It wins on the next IDLE evaluation, as a nested preempt.
- **EOI:** clears the highest set `isr` bit. EOI with `isr` equal to 0 is ignored.
- **Ack and EOI in the same cycle:** the EOI clear applies to the pre-ack `isr` value, then the ack sets its bit.
- **Ack in IDLE:** ignored.
- **Config writes:** take effect on the next cycle. Writing `mode` on a line reinitialises its pending bit to 0 (edge) or `smp` (level).
- **Reset values:** `mask`, `mode`, `pend`, `isr`, `smp` and `prev` reset to 0. The FSM resets to IDLE. All outputs reset to 0.
- **Reset mid-handshake:** `req` drops immediately (asynchronously). Any outstanding ack is discarded.

## Timing
- **Request latency:** a raw edge in cycle n appears in `smp` at n+1 and in `pend` at n+2. `irq2fc_req_o` rises at n+3 (add 2 cycles with the synchroniser).
- **Ack/withdraw:** ack sampled in cycle n drops `req` at n+1. The next `req` rises no earlier than n+2, so `req` is low for at least one cycle between vectors.
- **Withdraw:** takes effect on the cycle after the condition is registered.
- **Vector stability:** `irq2fc_vec_o` changes only on the cycle `req` rises.

## Configuration
- **`N1_IRQ_SYNC_EN` defined:** a two-flop synchroniser sits in front of `smp`, for asynchronous `irq_req_i` sources. All request latencies grow by 2 cycles.
- **`N1_IRQ_SYNC_EN` undefined:** `irq_req_i` must be synchronous to `clk_i`. Single-register sampling as described above.

## Test plan
- **Basic edge handshake:** mask=0x0010, mode=0x0010, enable=1, pulse line 4 -> `req`=1 with `vec`=4 at n+3. Ack -> `isr`=0x0010, `pend`=0, `req`=0. EOI -> `isr`=0.
- **Priority:** mask=0xFFFF, mode=0 (level), lines 2 and 9 both high -> `vec`=9. After ack of 9, line 2 stays blocked until EOI, then `vec`=2.
- **Nesting:** `isr`=0x0020 (line 5 in service), line 11 rises -> `vec`=11 is issued, ack -> `isr`=0x0820. EOI -> `isr`=0x0020. Second EOI -> 0. Third EOI -> no change.
- **Withdraw:** level line 7 in REQ drops before ack -> `req`=0 next cycle and `isr` unchanged. Repeat with `excpt2irq_en_i` cleared -> same result.
- **Simultaneous events:** edge on line 3 in the same cycle as the ack of vector 3 -> `pend[3]` stays 1 and a second `req` with `vec`=3 is issued. Ack plus EOI together with `isr`=0x0040 and `vec`=8 -> `isr`=0x0100.
- **Reset mid-operation:** assert `async_rst_i`=0 while `req`=1 -> all outputs are 0 immediately. After release, nothing is issued until `mask` is written.
